exec_unit_arbiter: RTL and testbench

- Shares one sequential shifter and one sequential 8-bit multiplier between two requesters (req ports 0 and 1).
- Arbitrates round-robin, latches the winner's operands and issues a one-cycle start to the selected unit.
- Waits for that unit's done, then returns the 8-bit result to the winner with a one-cycle response pulse.
- Sits between the decode/issue logic and the shared execution units; only one operation is in flight at a time.

---
 rtl/exec_unit_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_exec_unit_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit_arbiter.sv
// exec_unit_arbiter
// Round-robin arbiter that shares one sequential shifter and one sequential
// 8-bit multiplier between two requesters. One operation is in flight at a
// time: IDLE -> GRANT -> ISSUE -> (WAIT) -> RESP -> IDLE.
// All outputs are registered; unit data buses come straight from the
// operand registers latched when the winner is chosen.

module exec_unit_arbiter #(
    parameter logic [3:0] TIMEOUT = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    // requester 0
    input  logic       i_req0,
    input  logic       i_op0,
    input  logic [1:0] i_ctrl0,
    input  logic [7:0] i_a0,
    input  logic [7:0] i_b0,
    // requester 1
    input  logic       i_req1,
    input  logic       i_op1,
    input  logic [1:0] i_ctrl1,
    input  logic [7:0] i_a1,
    input  logic [7:0] i_b1,
    // grant / response
    output logic       o_gnt0,
    output logic       o_gnt1,
    output logic       o_rsp_valid0,
    output logic       o_rsp_valid1,
    output logic [7:0] o_rsp_data,
    output logic       o_rsp_err,
    // shifter
    output logic       o_sh_start,
    output logic [1:0] o_sh_ctrl,
    output logic [2:0] o_sh_amt,
    output logic [7:0] o_sh_data,
    input  logic       i_sh_done,
    input  logic [7:0] i_sh_result,
    // multiplier
    output logic       o_mul_start,
    output logic [7:0] o_mul_a,
    output logic [7:0] o_mul_b,
    input  logic       i_mul_done,
    input  logic [7:0] i_mul_result
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // Winner selection: a sole requester wins; on a tie the one that was
    // not granted last time wins.
    function automatic logic f_pick_winner(input logic req0,
                                           input logic req1,
                                           input logic last_gnt);
        logic win;
        if (req0 && req1) begin
            win = ~last_gnt;
        end else if (req1) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
        return win;
    endfunction

    state_t     r_state;
    state_t     w_next;

    // latched operation
    logic       r_id;
    logic       r_last_gnt;
    logic       r_op;
    logic [1:0] r_ctrl;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [3:0] r_cnt;

    // registered outputs
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_rsp_valid0;
    logic       r_rsp_valid1;
    logic [7:0] r_rsp_data;
    logic       r_rsp_err;
    logic       r_sh_start;
    logic       r_mul_start;

    // combinational helpers
    logic       w_any_req;
    logic       w_win;
    logic       w_bypass;
    logic       w_sel_done;
    logic [7:0] w_sel_result;
    logic [7:0] w_result;
    logic       w_err;
    logic [3:0] w_cnt_next;

    // Next-state, result and counter logic for the arbitration FSM.
    always_comb begin
        w_next       = r_state;
        w_result     = 8'd0;
        w_err        = 1'b0;
        w_cnt_next   = r_cnt;
        w_any_req    = i_req0 | i_req1;
        w_win        = f_pick_winner(i_req0, i_req1, r_last_gnt);
        // a zero shift amount would make the shifter wrap to 8 shifts
        w_bypass     = (r_op == 1'b0) && (r_b[2:0] == 3'd0);
        w_sel_done   = r_op ? i_mul_done   : i_sh_done;
        w_sel_result = r_op ? i_mul_result : i_sh_result;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_next = ST_GRANT;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_GRANT: begin
                w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                w_cnt_next = 4'd0;
                if (w_bypass) begin
                    w_next   = ST_RESP;
                    w_result = r_a;
                    w_err    = 1'b0;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // done only sampled here: the unit clears it at the start edge
                if (w_sel_done) begin
                    w_next   = ST_RESP;
                    w_result = w_sel_result;
                    w_err    = 1'b0;
                end else if (r_cnt == TIMEOUT) begin
                    w_next   = ST_RESP;
                    w_result = 8'd0;
                    w_err    = 1'b1;
                end else begin
                    w_next     = ST_WAIT;
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            ST_RESP: begin
                w_next     = ST_IDLE;
                w_cnt_next = 4'd0;
            end
            default: begin
                w_next     = ST_IDLE;
                w_cnt_next = 4'd0;
            end
        endcase
    end

    // State register and WAIT-cycle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Latch the winner's operands and id as the grant is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id       <= 1'b0;
            r_last_gnt <= 1'b1;
            r_op       <= 1'b0;
            r_ctrl     <= 2'd0;
            r_a        <= 8'd0;
            r_b        <= 8'd0;
        end else if ((r_state == ST_IDLE) && (w_next == ST_GRANT)) begin
            r_id       <= w_win;
            r_last_gnt <= w_win;
            r_op       <= w_win ? i_op1   : i_op0;
            r_ctrl     <= w_win ? i_ctrl1 : i_ctrl0;
            r_a        <= w_win ? i_a1    : i_a0;
            r_b        <= w_win ? i_b1    : i_b0;
        end else begin
            r_id       <= r_id;
            r_last_gnt <= r_last_gnt;
            r_op       <= r_op;
            r_ctrl     <= r_ctrl;
            r_a        <= r_a;
            r_b        <= r_b;
        end
    end

    // Output pulses registered from the upcoming state so they line up
    // with the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_sh_start   <= 1'b0;
            r_mul_start  <= 1'b0;
            r_rsp_valid0 <= 1'b0;
            r_rsp_valid1 <= 1'b0;
            r_rsp_data   <= 8'd0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_gnt0       <= (r_state == ST_IDLE) && (w_next == ST_GRANT) && !w_win;
            r_gnt1       <= (r_state == ST_IDLE) && (w_next == ST_GRANT) &&  w_win;
            r_sh_start   <= (r_state == ST_GRANT) && !r_op && (r_b[2:0] != 3'd0);
            r_mul_start  <= (r_state == ST_GRANT) &&  r_op;
            r_rsp_valid0 <= (w_next == ST_RESP) && (r_state != ST_RESP) && !r_id;
            r_rsp_valid1 <= (w_next == ST_RESP) && (r_state != ST_RESP) &&  r_id;
            r_rsp_data   <= ((w_next == ST_RESP) && (r_state != ST_RESP)) ? w_result : 8'd0;
            r_rsp_err    <= (w_next == ST_RESP) && (r_state != ST_RESP) && w_err;
        end
    end

    assign o_gnt0       = r_gnt0;
    assign o_gnt1       = r_gnt1;
    assign o_rsp_valid0 = r_rsp_valid0;
    assign o_rsp_valid1 = r_rsp_valid1;
    assign o_rsp_data   = r_rsp_data;
    assign o_rsp_err    = r_rsp_err;
    assign o_sh_start   = r_sh_start;
    assign o_sh_ctrl    = r_ctrl;
    assign o_sh_amt     = r_b[2:0];
    assign o_sh_data    = r_a;
    assign o_mul_start  = r_mul_start;
    assign o_mul_a      = r_a;
    assign o_mul_b      = r_b;

endmodule

// File: tb/tb_exec_unit_arbiter.sv
// Directed bench for exec_unit_arbiter with behavioural shifter/multiplier
// stubs and a response scoreboard.

module tb_exec_unit_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, op0, op1;
    logic [1:0] ctrl0, ctrl1;
    logic [7:0] a0, a1, b0, b1;
    logic       gnt0, gnt1, rsp_valid0, rsp_valid1, rsp_err;
    logic [7:0] rsp_data;
    logic       sh_start, sh_done, mul_start, mul_done;
    logic [1:0] sh_ctrl;
    logic [2:0] sh_amt;
    logic [7:0] sh_data, sh_result, mul_a, mul_b, mul_result;

    always #5 clk = ~clk;

    exec_unit_arbiter #(.TIMEOUT(4'd15)) dut (
        .clk(clk), .rst(rst),
        .i_req0(req0), .i_op0(op0), .i_ctrl0(ctrl0), .i_a0(a0), .i_b0(b0),
        .i_req1(req1), .i_op1(op1), .i_ctrl1(ctrl1), .i_a1(a1), .i_b1(b1),
        .o_gnt0(gnt0), .o_gnt1(gnt1),
        .o_rsp_valid0(rsp_valid0), .o_rsp_valid1(rsp_valid1),
        .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
        .o_sh_start(sh_start), .o_sh_ctrl(sh_ctrl), .o_sh_amt(sh_amt),
        .o_sh_data(sh_data), .i_sh_done(sh_done), .i_sh_result(sh_result),
        .o_mul_start(mul_start), .o_mul_a(mul_a), .o_mul_b(mul_b),
        .i_mul_done(mul_done), .i_mul_result(mul_result)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- unit stubs ----------------
    function automatic logic [7:0] shf(input logic [1:0] m, input logic [7:0] d, input logic [2:0] n);
        logic [15:0] t;
        t = {d, d} >> n;
        case (m)
            2'b00:   return d << n;
            2'b01:   return d >> n;
            2'b10:   return 8'($signed(d) >>> n);
            default: return t[7:0];
        endcase
    endfunction

    logic       sh_stall = 1'b0;
    logic       sh_busy, mul_busy;
    int         sh_left, mul_left;
    logic [7:0] sh_calc, mul_calc;

    // Shifter stub: done after sh_amt cycles, held until the next start.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_done <= 1'b0; sh_result <= 8'd0; sh_busy <= 1'b0; sh_left <= 0; sh_calc <= 8'd0;
        end else if (sh_start) begin
            sh_done <= 1'b0; sh_busy <= 1'b1; sh_left <= int'(sh_amt);
            sh_calc <= shf(sh_ctrl, sh_data, sh_amt);
        end else if (sh_busy && !sh_stall) begin
            if (sh_left == 1) begin
                sh_done <= 1'b1; sh_result <= sh_calc; sh_busy <= 1'b0;
            end else begin
                sh_left <= sh_left - 1;
            end
        end
    end

    // Multiplier stub: done after 8 cycles, held until the next start.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_done <= 1'b0; mul_result <= 8'd0; mul_busy <= 1'b0; mul_left <= 0; mul_calc <= 8'd0;
        end else if (mul_start) begin
            mul_done <= 1'b0; mul_busy <= 1'b1; mul_left <= 8;
            mul_calc <= 8'(16'(mul_a) * 16'(mul_b));
        end else if (mul_busy) begin
            if (mul_left == 1) begin
                mul_done <= 1'b1; mul_result <= mul_calc; mul_busy <= 1'b0;
            end else begin
                mul_left <= mul_left - 1;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    typedef struct { int id; logic [7:0] d; logic e; } exp_t;
    exp_t sb[$];
    int   gq[$];
    int   rsp_seen = 0;
    int   sh_starts = 0;
    int   mul_starts = 0;
    logic [2:0] last_amt = 3'd0;

    always @(negedge clk) begin
        if (!rst) begin
            exp_t x;
            if (sh_start) begin sh_starts++; last_amt = sh_amt; end
            if (mul_start) mul_starts++;
            if (gnt0) gq.push_back(0);
            if (gnt1) gq.push_back(1);
            if (rsp_valid0 || rsp_valid1) begin
                rsp_seen++;
                chk("rsp_onehot", {31'd0, rsp_valid0 & rsp_valid1}, 32'd0);
                chk("rsp_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    x = sb.pop_front();
                    chk("rsp_id", {31'd0, rsp_valid1}, x.id);
                    chk("rsp_data", {24'd0, rsp_data}, {24'd0, x.d});
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, x.e});
                end
            end else begin
                chk("rsp_data_idle", {24'd0, rsp_data}, 32'd0);
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic v, input logic op, input logic [1:0] c,
                         input logic [7:0] a, input logic [7:0] b);
        if (id == 0) begin req0 = v; op0 = op; ctrl0 = c; a0 = a; b0 = b; end
        else begin req1 = v; op1 = op; ctrl1 = c; a1 = a; b1 = b; end
    endtask

    // Single requester operation with latency checks (cycles from req drive).
    task automatic do_op(input string tag, input int id, input logic op, input logic [1:0] c,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic ee, input int elat);
        exp_t x;
        int n = 0;
        bit got = 0;
        int base = rsp_seen;
        x.id = id; x.d = ed; x.e = ee;
        sb.push_back(x);
        drive(id, 1'b1, op, c, a, b);
        while (!got && n < 30) begin
            step(); n++;
            if ((id == 0 && gnt0) || (id == 1 && gnt1)) got = 1;
        end
        chk({tag, "_gnt_lat"}, n, 1);
        drive(id, 1'b0, op, c, a, b);
        while (rsp_seen == base && n < 60) begin step(); n++; end
        chk({tag, "_rsp_lat"}, n, elat);
    endtask

    // Both requesters held high for n grants; expected order 0,1,0,1,...
    task automatic both(input string tag, input int n,
                        input logic op_0, input logic [7:0] a_0, input logic [7:0] b_0, input logic [7:0] d_0,
                        input logic op_1, input logic [7:0] a_1, input logic [7:0] b_1, input logic [7:0] d_1);
        exp_t x;
        int k = 0;
        int base = rsp_seen;
        gq.delete();
        for (int i = 0; i < n; i++) begin
            x.id = i % 2; x.d = (i % 2 == 0) ? d_0 : d_1; x.e = 1'b0;
            sb.push_back(x);
        end
        drive(0, 1'b1, op_0, 2'd0, a_0, b_0);
        drive(1, 1'b1, op_1, 2'd0, a_1, b_1);
        while (gq.size() < n && k < 300) begin step(); k++; end
        drive(0, 1'b0, op_0, 2'd0, a_0, b_0);
        drive(1, 1'b0, op_1, 2'd0, a_1, b_1);
        while (rsp_seen < base + n && k < 400) begin step(); k++; end
        chk({tag, "_rsp_count"}, rsp_seen - base, n);
        chk({tag, "_gnt_count"}, gq.size(), n);
        for (int i = 0; i < n && i < gq.size(); i++) chk({tag, "_gnt_order"}, gq[i], i % 2);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, {30'd0, gnt0, gnt1}, 32'd0);
        chk({tag, "_rsp_valid"}, {30'd0, rsp_valid0, rsp_valid1}, 32'd0);
        chk({tag, "_rsp"}, {23'd0, rsp_err, rsp_data}, 32'd0);
        chk({tag, "_starts"}, {30'd0, sh_start, mul_start}, 32'd0);
        chk({tag, "_sh_bus"}, {19'd0, sh_ctrl, sh_amt, sh_data}, 32'd0);
        chk({tag, "_mul_bus"}, {16'd0, mul_a, mul_b}, 32'd0);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int s0, m0, r0;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
        drive(1, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
        repeat (3) step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk_all_zero("post_reset");

        // multiply 5*7 on requester 0
        s0 = sh_starts; m0 = mul_starts;
        do_op("mul", 0, 1'b1, 2'd0, 8'd5, 8'd7, 8'd35, 1'b0, 12);
        chk("mul_start_pulses", mul_starts - m0, 1);
        chk("mul_no_sh_start", sh_starts - s0, 0);
        chk("mul_bus", {16'd0, mul_a, mul_b}, {16'd0, 8'd5, 8'd7});
        step();

        // shifts on requester 1
        s0 = sh_starts;
        do_op("lsl", 1, 1'b0, 2'b00, 8'h81, 8'd1, 8'h02, 1'b0, 5);
        chk("lsl_sh_start", sh_starts - s0, 1);
        chk("lsl_amt", {29'd0, last_amt}, 32'd1);
        step();
        do_op("asr", 1, 1'b0, 2'b10, 8'h80, 8'd3, 8'hF0, 1'b0, 7);
        chk("asr_amt", {29'd0, last_amt}, 32'd3);
        step();

        // bypass on requester 0
        s0 = sh_starts; m0 = mul_starts;
        do_op("bypass", 0, 1'b0, 2'b01, 8'h5A, 8'h08, 8'h5A, 1'b0, 3);
        chk("bypass_no_start", (sh_starts - s0) + (mul_starts - m0), 0);
        step();

        // timeout on a stalled shifter, then normal service
        sh_stall = 1'b1;
        do_op("timeout", 0, 1'b0, 2'b00, 8'h01, 8'd2, 8'h00, 1'b1, 19);
        sh_stall = 1'b0;
        step();
        do_op("ror", 1, 1'b0, 2'b11, 8'h01, 8'd1, 8'h80, 1'b0, 5);
        step();
        // mul_done is still high from the first multiply when this one issues
        do_op("mul2", 1, 1'b1, 2'd0, 8'h10, 8'h11, 8'h10, 1'b0, 12);
        step();

        // fairness with both requesters held high
        both("fair", 4, 1'b0, 8'h11, 8'h00, 8'h11, 1'b0, 8'h22, 8'h00, 8'h22);
        step();

        // reset in the middle of a multiply
        begin
            int k = 0;
            drive(0, 1'b1, 1'b1, 2'd0, 8'd9, 8'd9);
            while (!gnt0 && k < 20) begin step(); k++; end
            chk("rst_op_gnt", {31'd0, gnt0}, 32'd1);
            drive(0, 1'b0, 1'b1, 2'd0, 8'd9, 8'd9);
            repeat (4) step();
            r0 = rsp_seen;
            rst = 1'b1;
            #1;
            chk_all_zero("mid_reset");
            repeat (3) step();
            rst = 1'b0;
            repeat (14) step();
            chk("rst_no_rsp", rsp_seen - r0, 0);
        end
        // tie after reset: requester 0 first
        both("tie", 2, 1'b1, 8'd6, 8'd7, 8'd42, 1'b0, 8'h33, 8'h00, 8'h33);
        step();
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
